// File: rtl/qenc_pkg.sv
// qenc_pkg: shared Gray-state constants, step encoding and quadrature decode helper
package qenc_pkg;
  localparam int CNT_W_DEF = 16;
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;
  function automatic logic [1:0] gray_fwd(input logic [1:0] s);
    return (s == QS_00) ? QS_01 : (s == QS_01) ? QS_11 : (s == QS_11) ? QS_10 : QS_00;
  endfunction
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == cur) ? STEP_NONE :
           (cur == gray_fwd(prev)) ? STEP_FWD :
           (prev == gray_fwd(cur)) ? STEP_REV : STEP_ILLEGAL;
  endfunction
endpackage

// File: rtl/qenc_channel.sv
// qenc_channel: one encoder - synchroniser, optional glitch filter (QENC_FILTER_EN),
// priming, Gray decode, wrapping counter and sticky illegal-transition flag.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin_a,
  input  logic             pin_b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             err
);
  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("qenc_channel: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end
`ifdef QENC_FILTER_EN
  localparam int FILL = SYNC_STAGES + FILTER_LEN;
  localparam int FW   = $clog2(FILTER_LEN + 1);
`else
  localparam int FILL = SYNC_STAGES;
`endif
  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
  logic [FILL-1:0]        fill_q, fill_d;
  logic [1:0]             raw, cur, prev_q, prev_d;
  logic                   primed_q, primed_d, err_q, err_d;
  logic [CNT_W-1:0]       count_q, count_d;
  step_t                  step;
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], pin_a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], pin_b};
    fill_d   = {fill_q[FILL-2:0], 1'b1};
    raw      = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  end
`ifdef QENC_FILTER_EN
  logic [1:0]         filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = (raw[i] == filt_q[i]) ? '0 : fcnt_q[i] + FW'(1);
      if (fcnt_d[i] == FW'(FILTER_LEN)) begin
        filt_d[i] = raw[i];
        fcnt_d[i] = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  assign cur = filt_q;
`else
  assign cur = raw;
`endif
  // Stay unprimed until the pipeline carries real pin samples, so pins sitting
  // at a non-zero level through reset never decode as a step or an error.
  always_comb begin
    step     = decode_step(prev_q, cur);
    prev_d   = cur;
    primed_d = !clear && fill_q[FILL-1];
    count_d  = clear ? '0 :
               !primed_q ? count_q :
               (step == STEP_FWD) ? count_q + CNT_W'(1) :
               (step == STEP_REV) ? count_q - CNT_W'(1) : count_q;
    err_d    = !clear && (err_q || (primed_q && step == STEP_ILLEGAL));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      fill_q   <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      fill_q   <= fill_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  assign count = count_q;
  assign err   = err_q;
endmodule

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: two quadrature decoders with a registered count select.
// Optional input glitch filter enabled by defining QENC_FILTER_EN.
module quad_encoder_counter
  import qenc_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1A,
  input  logic             in1B,
  input  logic             in2A,
  input  logic             in2B,
  input  logic             en_choose,
  input  logic             clear,
  output logic [CNT_W-1:0] enval,
  output logic             err1,
  output logic             err2
);
  logic [CNT_W-1:0] count1, count2, enval_q, enval_d;
  qenc_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_ch1 (
    .clk(clk), .rst(rst), .pin_a(in1A), .pin_b(in1B), .clear(clear), .count(count1), .err(err1)
  );
  qenc_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_ch2 (
    .clk(clk), .rst(rst), .pin_a(in2A), .pin_b(in2B), .clear(clear), .count(count2), .err(err2)
  );
  always_comb enval_d = en_choose ? count2 : count1;
  always_ff @(posedge clk or posedge rst)
    if (rst) enval_q <= '0;
    else enval_q <= enval_d;
  assign enval = enval_q;
endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb_quad_encoder_counter: directed table plus hand sequences for latency, clear, wrap and reset.
module tb_quad_encoder_counter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a1 = 1'b0, b1 = 1'b0, a2 = 1'b0, b2 = 1'b0, sel = 1'b0, clr = 1'b0;
  logic [15:0] enval;
  logic        err1, err2;
  int          total = 0, bad = 0;
  typedef struct {
    logic        a1, b1, a2, b2, sel, clr;
    logic [15:0] ev;
    logic        e1, e2;
  } vec_t;
  vec_t tbl [13];
  quad_encoder_counter dut (
    .clk(clk), .rst(rst), .in1A(a1), .in1B(b1), .in2A(a2), .in2B(b2),
    .en_choose(sel), .clear(clr), .enval(enval), .err1(err1), .err2(err2)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  function automatic logic [1:0] nxt(input logic [1:0] s);
    case (s)
      2'b00: nxt = 2'b01;
      2'b01: nxt = 2'b11;
      2'b11: nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
  endfunction
  function automatic logic [1:0] prv(input logic [1:0] s);
    case (s)
      2'b00: prv = 2'b10;
      2'b10: prv = 2'b11;
      2'b11: prv = 2'b01;
      default: prv = 2'b00;
    endcase
  endfunction
  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  initial begin
    logic [1:0] st;
    //            a1    b1    a2    b2    sel   clr   enval     e1    e2
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    // reset with encoder 1 pins high: priming must absorb the 11 level
    a1 = 1'b1; b1 = 1'b1;
    repeat (3) tick();
    check("rst_enval", enval, 16'h0000);
    check("rst_err1", {15'd0, err1}, 16'd0);
    check("rst_err2", {15'd0, err2}, 16'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("prime_enval", enval, 16'h0000);
    check("prime_err1", {15'd0, err1}, 16'd0);
    rst = 1'b1; a1 = 1'b0; b1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    // first step latency: pin change before edge k, enval at k+3
    b1 = 1'b1;
    repeat (3) tick();
    check("lat_k+2", enval, 16'h0000);
    tick();
    check("lat_k+3", enval, 16'h0001);
    repeat (4) tick();
    for (int i = 0; i < 13; i++) begin
      a1 = tbl[i].a1; b1 = tbl[i].b1; a2 = tbl[i].a2; b2 = tbl[i].b2;
      sel = tbl[i].sel; clr = tbl[i].clr;
      tick();
      clr = 1'b0;
      repeat (7) tick();
      check($sformatf("vec%0d_enval", i), enval, tbl[i].ev);
      check($sformatf("vec%0d_err1", i), {15'd0, err1}, {15'd0, tbl[i].e1});
      check($sformatf("vec%0d_err2", i), {15'd0, err2}, {15'd0, tbl[i].e2});
    end
    // en_choose shows after one cycle: count1=FFFF, count2=0
    sel = 1'b0;
    tick();
    check("sel_1cyc", enval, 16'hFFFF);
    // clear clears flags at once, enval one cycle later
    pulse_clear();
    check("clr_err2", {15'd0, err2}, 16'd0);
    check("clr_enval_old", enval, 16'hFFFF);
    tick();
    check("clr_enval_0", enval, 16'h0000);
    // wrap: 32767 forward steps, then one more
    repeat (3) tick();
    st = {a1, b1};
    for (int i = 0; i < 32767; i++) begin
      st = nxt(st);
      {a1, b1} = st;
      tick();
    end
    repeat (4) tick();
    check("wrap_7fff", enval, 16'h7FFF);
    st = nxt(st);
    {a1, b1} = st;
    repeat (5) tick();
    check("wrap_8000", enval, 16'h8000);
    pulse_clear();
    repeat (3) tick();
    check("wrap_clr", enval, 16'h0000);
    st = prv(st);
    {a1, b1} = st;
    repeat (5) tick();
    check("wrap_ffff", enval, 16'hFFFF);
    // async reset mid-cycle
    #2 rst = 1'b1;
    #1 check("async_rst", enval, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst", enval, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
